// File: rtl/spi_image_loader_if.sv
// Boot-port bundle between the image loader, the SPI storage controller and the SRAM controller.
// The master side is the loader; the slave side is the storage/memory controllers (or a bench).
interface spi_image_loader_if;
  logic        i_spiMISO;
  logic        o_spiMOSI;
  logic        o_spiEn;
  logic [15:0] o_memAddr;
  logic [15:0] o_memDataOut;
  logic        o_memEn;
  logic        o_smNowBooted;

  modport master (
    input  i_spiMISO,
    output o_spiMOSI,
    output o_spiEn,
    output o_memAddr,
    output o_memDataOut,
    output o_memEn,
    output o_smNowBooted
  );

  modport slave (
    output i_spiMISO,
    input  o_spiMOSI,
    input  o_spiEn,
    input  o_memAddr,
    input  o_memDataOut,
    input  o_memEn,
    input  o_smNowBooted
  );
endinterface

// File: rtl/spi_image_loader.sv
// Boot-time copier: issues an EEPROM READ, takes a 16-bit word count, then streams that many
// words into SRAM through the boot port and raises the sticky booted flag.
module spi_image_loader #(
  parameter logic [15:0] MAX_WORDS = 16'hC000,
  parameter logic [15:0] EE_ADDR   = 16'h0000
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  spi_image_loader_if.master bus
);

  localparam logic [7:0] READ_CMD = 8'h03;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StLen, StData, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] len_q, len_d;
  logic [15:0] shift_q, shift_d;
  logic        mosi_q, mosi_d;
  logic        spi_en_q, spi_en_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        mem_en_q, mem_en_d;
  logic        booted_q, booted_d;

  logic [15:0] rx_word;
  assign rx_word = {shift_q[14:0], bus.i_spiMISO};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      word_cnt_q <= 16'd0;
      len_q      <= 16'd0;
      shift_q    <= 16'd0;
      mosi_q     <= 1'b0;
      spi_en_q   <= 1'b0;
      mem_addr_q <= 16'd0;
      mem_data_q <= 16'd0;
      mem_en_q   <= 1'b0;
      booted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      mosi_q     <= mosi_d;
      spi_en_q   <= spi_en_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_en_q   <= mem_en_d;
      booted_q   <= booted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_en_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d   = StCmd;
        bit_cnt_d = 4'd0;
      end
      StCmd: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) begin
          state_d   = StAddr;
          bit_cnt_d = 4'd0;
        end
      end
      StAddr: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) state_d = StLen;
      end
      StLen: begin
        shift_d   = rx_word;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          // Clamp keeps every write below the mapped-register region.
          len_d      = (rx_word > MAX_WORDS) ? MAX_WORDS : rx_word;
          word_cnt_d = 16'd0;
          state_d    = (len_d == 16'd0) ? StDone : StData;
        end
      end
      StData: begin
        shift_d   = rx_word;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          mem_en_d   = 1'b1;
          mem_addr_d = word_cnt_q;
          mem_data_d = rx_word;
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_q == len_q - 16'd1) state_d = StDone;
        end
      end
      StDone: begin
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with the bit being shifted.
    spi_en_d = (state_d == StCmd) || (state_d == StAddr) || (state_d == StLen) ||
               (state_d == StData);
    mosi_d = 1'b0;
    if (state_d == StCmd) begin
      mosi_d = READ_CMD[3'd7 - bit_cnt_d[2:0]];
    end else if (state_d == StAddr) begin
      mosi_d = EE_ADDR[4'd15 - bit_cnt_d];
    end

    // The final strobe and booted never share a cycle; an empty image boots immediately.
    booted_d = booted_q | ((state_d == StDone) && !mem_en_d);
  end

  assign bus.o_spiMOSI     = mosi_q;
  assign bus.o_spiEn       = spi_en_q;
  assign bus.o_memAddr     = mem_addr_q;
  assign bus.o_memDataOut  = mem_data_q;
  assign bus.o_memEn       = mem_en_q;
  assign bus.o_smNowBooted = booted_q;

endmodule

// File: tb/tb_spi_image_loader.sv
// Bench for spi_image_loader: a reactive EEPROM model serves the image, and each copy is
// checked against timings and contents derived from the image header and words.
module tb_spi_image_loader;
  localparam logic [15:0] MaxWords = 16'd4;
  localparam logic [15:0] EeAddr   = 16'h0000;
  localparam logic [7:0]  ReadCmd  = 8'h03;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  spi_image_loader_if bus ();

  spi_image_loader #(
    .MAX_WORDS(MaxWords),
    .EE_ADDR  (EeAddr)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] image [$];  // header followed by payload words
  int          spi_bits;
  logic [23:0] mosi_log;
  int          mosi_stray;
  int          en_first;
  int          en_cnt;
  int          boot_cyc;
  int          dbl_strobe;
  logic        prev_en;
  int          st_cyc  [$];
  logic [15:0] st_addr [$];
  logic [15:0] st_data [$];

  initial bus.i_spiMISO = 1'b0;

  task automatic clear_logs();
    spi_bits   = 0;
    mosi_log   = '0;
    mosi_stray = 0;
    en_first   = -1;
    en_cnt     = 0;
    boot_cyc   = -1;
    dbl_strobe = 0;
    prev_en    = 1'b0;
    st_cyc.delete();
    st_addr.delete();
    st_data.delete();
  endtask

  // EEPROM model and observer: one SPI bit per cycle while o_spiEn is high.
  always @(posedge clk) begin
    logic        r;
    int          n;
    int          w;
    logic [15:0] tmp;
    r = rstn;
    #1;
    if (!r) cyc = 0;
    else cyc++;
    n = spi_bits;
    if (bus.o_spiEn) begin
      if (n < 24) mosi_log[23 - n] = bus.o_spiMOSI;
      else if (bus.o_spiMOSI) mosi_stray++;
      if (en_first < 0) en_first = cyc;
      en_cnt++;
      spi_bits++;
    end else if (bus.o_spiMOSI) begin
      mosi_stray++;
    end
    bus.i_spiMISO = 1'($urandom_range(0, 1));
    if (bus.o_spiEn && n >= 24) begin
      w = (n - 24) / 16;
      if (w < image.size()) begin
        tmp = image[w];
        bus.i_spiMISO = tmp[15 - ((n - 24) % 16)];
      end
    end
    if (bus.o_memEn) begin
      st_cyc.push_back(cyc);
      st_addr.push_back(bus.o_memAddr);
      st_data.push_back(bus.o_memDataOut);
      if (prev_en) dbl_strobe++;
    end
    prev_en = bus.o_memEn;
    if (bus.o_smNowBooted && boot_cyc < 0) boot_cyc = cyc;
  end

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    rstn = 1'b1;
  endtask

  task automatic build_image(input logic [15:0] hdr, input int nwords);
    image.delete();
    image.push_back(hdr);
    for (int i = 0; i < nwords; i++) image.push_back(16'($urandom));
  endtask

  task automatic wait_booted(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (boot_cyc >= 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s boot_timeout: booted=%b required 1 within 300 cycles", name,
               bus.o_smNowBooted);
    end
  endtask

  task automatic check_copy(input string name);
    int len;
    int exp_boot;
    int n;
    len      = (image[0] > MaxWords) ? int'(MaxWords) : int'(image[0]);
    exp_boot = (len == 0) ? 41 : 42 + 16 * len;
    repeat (20) @(negedge clk);
    checks++;
    if (mosi_log !== {ReadCmd, EeAddr}) begin
      errors++;
      $display("FAIL %s mosi_cmd_addr: got %h required %h", name, mosi_log, {ReadCmd, EeAddr});
    end
    checks++;
    if (mosi_stray !== 0) begin
      errors++;
      $display("FAIL %s mosi_idle_zero: got %0d high cycles required 0", name, mosi_stray);
    end
    checks++;
    if (en_first !== 1) begin
      errors++;
      $display("FAIL %s spi_en_start: got cycle %0d required 1", name, en_first);
    end
    checks++;
    if (en_cnt !== 40 + 16 * len) begin
      errors++;
      $display("FAIL %s spi_en_len: got %0d required %0d", name, en_cnt, 40 + 16 * len);
    end
    checks++;
    if (boot_cyc !== exp_boot) begin
      errors++;
      $display("FAIL %s booted_cycle: got %0d required %0d", name, boot_cyc, exp_boot);
    end
    checks++;
    if (st_cyc.size() !== len) begin
      errors++;
      $display("FAIL %s strobe_count: got %0d required %0d", name, st_cyc.size(), len);
    end
    n = (st_cyc.size() < len) ? st_cyc.size() : len;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (st_cyc[k] !== 57 + 16 * k || st_addr[k] !== 16'(k) || st_data[k] !== image[k + 1]) begin
        errors++;
        $display("FAIL %s write%0d: got cyc %0d addr %h data %h required cyc %0d addr %h data %h",
                 name, k, st_cyc[k], st_addr[k], st_data[k], 57 + 16 * k, 16'(k), image[k + 1]);
      end
    end
    checks++;
    if (dbl_strobe !== 0) begin
      errors++;
      $display("FAIL %s strobe_width: got %0d wide strobes required 0", name, dbl_strobe);
    end
    if (len > 0) begin
      checks++;
      if (bus.o_memAddr !== 16'(len - 1) || bus.o_memDataOut !== image[len]) begin
        errors++;
        $display("FAIL %s output_hold: got %h/%h required %h/%h", name, bus.o_memAddr,
                 bus.o_memDataOut, 16'(len - 1), image[len]);
      end
    end
    checks++;
    if ({bus.o_smNowBooted, bus.o_spiEn, bus.o_memEn} !== 3'b100) begin
      errors++;
      $display("FAIL %s done_state: got booted/en/memEn %b required 100", name,
               {bus.o_smNowBooted, bus.o_spiEn, bus.o_memEn});
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.o_spiMOSI, bus.o_spiEn, bus.o_memEn, bus.o_smNowBooted, bus.o_memAddr,
         bus.o_memDataOut} !== 36'd0) begin
      errors++;
      $display("FAIL reset_values: got mosi/en/memEn/booted %b addr %h data %h required all 0",
               {bus.o_spiMOSI, bus.o_spiEn, bus.o_memEn, bus.o_smNowBooted}, bus.o_memAddr,
               bus.o_memDataOut);
    end
  endtask

  task automatic test_three_word();
    image.delete();
    image.push_back(16'h0003);
    image.push_back(16'hA5A5);
    image.push_back(16'h1234);
    image.push_back(16'hFFFF);
    apply_reset();
    wait_booted("three_word");
    check_copy("three_word");
    checks++;
    if (boot_cyc !== 90 || en_cnt !== 88) begin
      errors++;
      $display("FAIL three_word_fixed: got booted %0d en %0d required 90 88", boot_cyc, en_cnt);
    end
  endtask

  task automatic test_empty();
    build_image(16'h0000, 4);
    apply_reset();
    wait_booted("empty");
    check_copy("empty");
  endtask

  task automatic test_clamp();
    build_image(16'h0010, 16);
    apply_reset();
    wait_booted("clamp");
    check_copy("clamp");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      build_image(16'($urandom_range(0, 7)), 8);
      apply_reset();
      wait_booted("random");
      check_copy("random");
    end
  endtask

  task automatic test_reset_mid_copy();
    build_image(16'h0003, 3);
    apply_reset();
    for (int i = 0; i < 200 && cyc < 62; i++) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.o_spiMOSI, bus.o_spiEn, bus.o_memEn, bus.o_smNowBooted, bus.o_memAddr,
         bus.o_memDataOut} !== 36'd0) begin
      errors++;
      $display("FAIL mid_reset_async: got en %b addr %h data %h required all 0", bus.o_spiEn,
               bus.o_memAddr, bus.o_memDataOut);
    end
    checks++;
    if (st_cyc.size() !== 1) begin
      errors++;
      $display("FAIL mid_reset_progress: got %0d strobes before reset required 1", st_cyc.size());
    end
    apply_reset();
    wait_booted("mid_reset");
    check_copy("mid_reset");
  endtask

  task automatic test_sticky_done();
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.o_spiEn || bus.o_memEn || bus.o_spiMOSI || !bus.o_smNowBooted) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL sticky_done: got %0d bad cycles required 0", bad);
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_three_word();
    test_empty();
    test_clamp();
    test_random();
    test_reset_mid_copy();
    test_sticky_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
